// File: rtl/rvv_red_sequencer.sv
// Multi-beat RVV reduction: NB_LANES elements per beat folded through a lane tree into a SEW-wide accumulator.
// done pulses B+1 cycles after an accepted start (1 for vl=0/illegal); start is ignored unless idle, with no stall or backpressure.
module rvv_red_sequencer #(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [1:0]        vsew,
    input  logic [16:0]       vl,
    input  logic              masked,
    input  logic [31:0]       vs1_scalar,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN/8-1:0] mask,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              illegal
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  sew_q;
    logic        masked_q;
    logic [16:0] evl_q;
    logic [16:0] idx;
    logic [31:0] acc;

    function automatic logic [31:0] sext_sew(input logic [31:0] v, input logic [1:0] sew);
        case (sew)
            2'b00:   return {{24{v[7]}}, v[7:0]};
            2'b01:   return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] zext_sew(input logic [31:0] v, input logic [1:0] sew);
        case (sew)
            2'b00:   return {24'h0, v[7:0]};
            2'b01:   return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Only the low SEW bits of either operand are meaningful; upper bits are don't-care.
    function automatic logic [31:0] op_apply(input logic [2:0] o, input logic [1:0] sew,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa, sb, za, zb;
        sa = sext_sew(a, sew);
        sb = sext_sew(b, sew);
        za = zext_sew(a, sew);
        zb = zext_sew(b, sew);
        case (o)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return (za < zb) ? a : b;
            3'd5:    return ($signed(sa) < $signed(sb)) ? a : b;
            3'd6:    return (za > zb) ? a : b;
            default: return ($signed(sa) > $signed(sb)) ? a : b;
        endcase
    endfunction

    function automatic logic [31:0] op_identity(input logic [2:0] o, input logic [1:0] sew);
        case (o)
            3'd1, 3'd4: return 32'hFFFF_FFFF;
            3'd5:       return (sew == 2'b00) ? 32'h7F : (sew == 2'b01) ? 32'h7FFF : 32'h7FFF_FFFF;
            3'd7:       return (sew == 2'b00) ? 32'h80 : (sew == 2'b01) ? 32'h8000 : 32'h8000_0000;
            default:    return 32'h0;
        endcase
    endfunction

    logic [31:0] max_el;
    logic [16:0] evl_in;
    assign max_el = 32'(VLEN) >> (32'(vsew) + 32'd3);
    assign evl_in = (32'(vl) < max_el) ? vl : max_el[16:0];

    // Heap-ordered tree: leaves at NB_LANES-1.., node i combines children 2i+1 and 2i+2.
    logic [31:0] node [2*NB_LANES-1];
    logic [31:0] elem_idx;
    logic [31:0] elem;
    logic        mbit;
    logic [31:0] tree_out;
    logic [31:0] beat_acc;

    always_comb begin
        elem_idx = '0;
        elem     = '0;
        mbit     = 1'b0;
        for (int i = 0; i < 2*NB_LANES-1; i++) node[i] = '0;
        for (int l = 0; l < NB_LANES; l++) begin
            elem_idx = 32'(idx) + 32'(l);
            elem     = 32'(vs2 >> (elem_idx << (32'(sew_q) + 32'd3)));
            mbit     = 1'(mask >> elem_idx);
            node[NB_LANES-1+l] = (elem_idx < 32'(evl_q) && (!masked_q || mbit))
                                 ? elem : op_identity(op_q, sew_q);
        end
        for (int i = NB_LANES-2; i >= 0; i--)
            node[i] = op_apply(op_q, sew_q, node[2*i+1], node[2*i+2]);
        tree_out = node[0];
    end

    assign beat_acc = op_apply(op_q, sew_q, acc, tree_out);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            result   <= '0;
            acc      <= '0;
            idx      <= '0;
            op_q     <= '0;
            sew_q    <= '0;
            masked_q <= 1'b0;
            evl_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        sew_q    <= vsew;
                        masked_q <= masked;
                        evl_q    <= evl_in;
                        acc      <= vs1_scalar;
                        idx      <= '0;
                        if (vsew == 2'b11) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            result  <= '0;
                        end else if (evl_in == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= sext_sew(vs1_scalar, vsew);
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc <= beat_acc;
                    idx <= idx + 17'(NB_LANES);
                    if (idx + 17'(NB_LANES) >= evl_q) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= sext_sew(beat_acc, sew_q);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_red_sequencer.sv
// Randomized and directed bench for rvv_red_sequencer against an element-by-element reference model.
module tb_rvv_red_sequencer;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [2:0]   op;
    logic [1:0]   vsew;
    logic [16:0]  vl;
    logic         masked;
    logic [31:0]  vs1_scalar;
    logic [127:0] vs2;
    logic [15:0]  mask;
    logic         busy;
    logic         done;
    logic [31:0]  result;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    rvv_red_sequencer #(.VLEN(128), .NB_LANES(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .vsew(vsew), .vl(vl),
        .masked(masked), .vs1_scalar(vs1_scalar), .vs2(vs2), .mask(mask),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint to_s(input longint unsigned x, input longint unsigned half);
        return (x >= half) ? longint'(x) - longint'(half * 2) : longint'(x);
    endfunction

    function automatic logic [31:0] ref_red(input logic [2:0] o, input logic [1:0] s, input logic [16:0] l,
                                            input logic m, input logic [31:0] seed,
                                            input logic [127:0] v, input logic [15:0] mk);
        int w, n, evl;
        longint unsigned full, half, acc, x;
        logic [127:0] tmp;
        if (s == 2'b11) return 32'h0;
        w    = 8 << s;
        n    = 128 / w;
        evl  = (int'(l) < n) ? int'(l) : n;
        full = (64'd1 << w) - 1;
        half = 64'd1 << (w - 1);
        acc  = {32'h0, seed} & full;
        for (int e = 0; e < evl; e++) begin
            if (!m || mk[e]) begin
                tmp = v >> (e * w);
                x   = tmp[63:0] & full;
                case (o)
                    3'd0: acc = (acc + x) & full;
                    3'd1: acc = acc & x;
                    3'd2: acc = acc | x;
                    3'd3: acc = acc ^ x;
                    3'd4: if (x < acc) acc = x;
                    3'd5: if (to_s(x, half) < to_s(acc, half)) acc = x;
                    3'd6: if (x > acc) acc = x;
                    default: if (to_s(x, half) > to_s(acc, half)) acc = x;
                endcase
            end
        end
        if (acc >= half) acc = acc | ~full;
        return acc[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] s, input logic [16:0] l);
        int n, evl;
        if (s == 2'b11) return 1;
        n   = 128 >> (s + 3);
        evl = (int'(l) < n) ? int'(l) : n;
        return (evl + 3) / 4 + 1;
    endfunction

    // poke_at > 0 pulses a conflicting start that many cycles after the accepted one.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s, input logic [16:0] l,
                          input logic m, input logic [31:0] seed, input logic [127:0] v,
                          input logic [15:0] mk, input int poke_at);
        logic [31:0] exp_res;
        int exp_lat, cnt, busy_cnt;
        bit seen;
        exp_res = ref_red(o, s, l, m, seed, v, mk);
        exp_lat = ref_lat(s, l);
        @(negedge clk);
        op = o; vsew = s; vl = l; masked = m; vs1_scalar = seed; vs2 = v; mask = mk;
        start = 1'b1;
        cnt = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            start = !seen && (cnt == poke_at);
            if (start) begin
                op = ~o; vl = 17'd3; vs1_scalar = ~seed; masked = ~m;
            end
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_ill"}, 32'(illegal), 32'(s == 2'b11));
    endtask

    initial begin
        logic [127:0] vv;
        int seen_done;
        resetn = 1'b0; start = 1'b0; op = '0; vsew = '0; vl = '0; masked = 1'b0;
        vs1_scalar = '0; vs2 = '0; mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_res", result, 32'd0);
        resetn = 1'b1;

        for (int e = 0; e < 16; e++) vv[e*8 +: 8] = 8'(e + 1);
        run_op("sum8", 3'd0, 2'b00, 17'd16, 1'b0, 32'd10, vv, 16'h0, 0);
        chk("sum8_spec", result, 32'hFFFF_FF92);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);

        vv = {16'h5, 16'h4, 16'h3, 16'hFFFF, 16'h2, 16'h1, 16'h7FFF, 16'h8000, 64'h0};
        vv = vv >> 64;
        run_op("max16", 3'd7, 2'b01, 17'd8, 1'b0, 32'hFFFF, vv, 16'h0, 0);
        chk("max16_spec", result, 32'h0000_7FFF);
        run_op("maxu16", 3'd6, 2'b01, 17'd8, 1'b0, 32'hFFFF, vv, 16'h0, 0);
        chk("maxu16_spec", result, 32'hFFFF_FFFF);

        vv = {32'd3, 32'd9, 32'd1, 32'd5};
        run_op("minu_m", 3'd4, 2'b10, 17'd4, 1'b1, 32'd7, vv, 16'b1101, 0);
        chk("minu_m_spec", result, 32'd3);
        run_op("minu_m0", 3'd4, 2'b10, 17'd4, 1'b1, 32'd7, vv, 16'h0, 0);
        chk("minu_m0_spec", result, 32'd7);

        vv = {{11{8'hFF}}, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        run_op("xor8", 3'd3, 2'b00, 17'd5, 1'b0, 32'd0, vv, 16'h0, 0);
        chk("xor8_spec", result, 32'h1F);

        vv = {$urandom, $urandom, $urandom, $urandom};
        run_op("clamp32", 3'd0, 2'b10, 17'd40, 1'b0, 32'h1234, vv, 16'h0, 0);
        run_op("vl0", 3'd2, 2'b10, 17'd0, 1'b0, 32'hCAFE_F00D, vv, 16'h0, 0);
        chk("vl0_spec", result, 32'hCAFE_F00D);
        run_op("illegal", 3'd0, 2'b11, 17'd8, 1'b0, 32'h55, vv, 16'h0, 0);

        // Conflicting start mid-RUN must not disturb the running reduction.
        run_op("poke", 3'd0, 2'b00, 17'd16, 1'b0, 32'd3, vv, 16'h0, 2);

        // Reset mid-RUN aborts with no done pulse.
        @(negedge clk);
        op = 3'd0; vsew = 2'b00; vl = 17'd16; masked = 1'b0; vs1_scalar = 32'h9; vs2 = vv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_res", result, 32'd0);
        resetn = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("midrst_nodone", 32'(seen_done), 32'd0);

        // Consecutive calls start in the IDLE cycle right after done.
        run_op("b2b_a", 3'd1, 2'b00, 17'd7, 1'b0, 32'hFF, vv, 16'h0, 0);
        run_op("b2b_b", 3'd5, 2'b01, 17'd6, 1'b1, 32'h1234, vv, 16'hA5, 0);

        for (int k = 0; k < 150; k++) begin
            logic [1:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_op("rnd", 3'($urandom_range(0, 7)), rs, 17'($urandom_range(0, 40)),
                   1'($urandom_range(0, 1)), $urandom,
                   {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
